// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Latency (zero-wait memory): ALU/BR/JMP 3, ST 3, LD 4, HALT 2 cycles; each wait adds one.
// Backpressure: mem_req held until mem_ready; a stall of 2**TIMEOUT_W-1 cycles halts with err.
module multicycle_sequencer #(
    parameter int TIMEOUT_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             n,
    input  logic             z,
    input  logic             p,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_we,
    output logic             wdata_sel,
    output logic             flags_we,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t               st;
    logic [TIMEOUT_W-1:0] tmo;
    logic [TIMEOUT_W-1:0] tmo_inc;
    logic [CNT_W-1:0]     retired_q;
    logic                 err_q;

    logic op_alu, op_st, op_ld, op_jmp, op_halt, br_taken;
    logic mem_phase, tmo_hit, retire;

    assign op_alu  = (opcode <= 4'b1000);
    assign op_st   = (opcode == 4'b1001);
    assign op_ld   = (opcode == 4'b1010);
    assign op_jmp  = (opcode == 4'b1110);
    assign op_halt = (opcode == 4'b1111);

    always_comb begin
        br_taken = 1'b0;
        case (opcode)
            4'b1011: br_taken = z;
            4'b1100: br_taken = n;
            4'b1101: br_taken = p;
            default: br_taken = 1'b0;
        endcase
    end

    // Timeout fires on the stall cycle whose increment would bring the counter to all-ones.
    assign mem_phase = (st == S_FETCH) || (st == S_MEM);
    assign tmo_inc   = tmo + 1'b1;
    assign tmo_hit   = mem_phase && !mem_ready && (tmo_inc == {TIMEOUT_W{1'b1}});

    assign retire = ((st == S_DECODE) && op_halt) ||
                    (st == S_EXEC) ||
                    ((st == S_MEM) && mem_ready && op_st) ||
                    (st == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            tmo       <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (retire && (retired_q != {CNT_W{1'b1}}))
                retired_q <= retired_q + 1'b1;
            case (st)
                S_IDLE: begin
                    if (start) begin
                        st  <= S_FETCH;
                        tmo <= '0;
                    end
                end
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        tmo <= '0;
                        if (st == S_FETCH)
                            st <= S_DECODE;
                        else
                            st <= op_st ? S_FETCH : S_WB;
                    end else if (tmo_hit) begin
                        st    <= S_HALT;
                        err_q <= 1'b1;
                    end else begin
                        tmo <= tmo_inc;
                    end
                end
                S_DECODE: begin
                    tmo <= '0;
                    if (op_halt)
                        st <= S_HALT;
                    else if (op_ld || op_st)
                        st <= S_MEM;
                    else
                        st <= S_EXEC;
                end
                S_EXEC, S_WB: begin
                    st  <= S_FETCH;
                    tmo <= '0;
                end
                S_HALT: begin
                    if (start) begin
                        st    <= S_FETCH;
                        tmo   <= '0;
                        err_q <= 1'b0;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        reg_we       = 1'b0;
        wdata_sel    = 1'b0;
        flags_we     = 1'b0;
        case (st)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            S_EXEC: begin
                reg_we   = op_alu;
                flags_we = op_alu;
                pc_we    = br_taken || op_jmp;
                pc_sel   = br_taken || op_jmp;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = op_st;
            end
            S_WB: begin
                reg_we    = 1'b1;
                wdata_sel = 1'b1;
                flags_we  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (st != S_IDLE) && (st != S_HALT);
    assign halted  = (st == S_HALT);
    assign err     = err_q;
    assign retired = retired_q;
    assign state   = st;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle vector table plus timeout and reset sequences.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  opcode;
    logic        n, z, p;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel;
    logic        reg_we, wdata_sel, flags_we, busy, halted, err;
    logic [15:0] retired;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.TIMEOUT_W(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .opcode       (opcode),
        .n            (n),
        .z            (z),
        .p            (p),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .reg_we       (reg_we),
        .wdata_sel    (wdata_sel),
        .flags_we     (flags_we),
        .busy         (busy),
        .halted       (halted),
        .err          (err),
        .retired      (retired),
        .state        (state)
    );

    // {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we, wdata_sel, flags_we, busy, halted, err}
    logic [11:0] outs;
    assign outs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                   reg_we, wdata_sel, flags_we, busy, halted, err};

    localparam logic [11:0] O_IDL  = 12'b0000_0000_0000;
    localparam logic [11:0] O_FR   = 12'b1001_1000_0100;
    localparam logic [11:0] O_FW   = 12'b1000_0000_0100;
    localparam logic [11:0] O_DEC  = 12'b0000_0000_0100;
    localparam logic [11:0] O_ALU  = 12'b0000_0010_1100;
    localparam logic [11:0] O_BRT  = 12'b0000_1100_0100;
    localparam logic [11:0] O_MLD  = 12'b1010_0000_0100;
    localparam logic [11:0] O_MST  = 12'b1110_0000_0100;
    localparam logic [11:0] O_WB   = 12'b0000_0011_1100;
    localparam logic [11:0] O_HLT  = 12'b0000_0000_0010;

    typedef struct packed {
        logic        start;
        logic [3:0]  op;
        logic [2:0]  nzp;
        logic        rdy;
        logic [2:0]  st;
        logic [11:0] o;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs[0:63];
    int   nv = 0;

    task automatic add(input logic s, input logic [3:0] op, input logic [2:0] nzp,
                       input logic rdy, input logic [2:0] st, input logic [11:0] o,
                       input logic [15:0] ret);
        vecs[nv] = {s, op, nzp, rdy, st, o, ret};
        nv++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive just after the falling edge, sample 1 time unit later.
    task automatic cyc(input logic s, input logic [3:0] op, input logic [2:0] nzp, input logic rdy);
        @(negedge clk);
        start     = s;
        opcode    = op;
        {n, z, p} = nzp;
        mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; opcode = 4'd0; {n, z, p} = 3'b000; mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int  n_fetch;
    logic bad_we;
    logic saw_mem;

    initial begin
        rst_n = 1'b0;
        start = 1'b0; opcode = 4'd0; {n, z, p} = 3'b000; mem_ready = 1'b0;
        #1;
        chk("reset_state", {state, outs, retired}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //   start op       nzp     rdy st    outs   retired
        add(1, 4'b0000, 3'b000, 1, 3'd0, O_IDL, 16'd0);
        add(0, 4'b0000, 3'b000, 1, 3'd1, O_FR,  16'd0);
        add(0, 4'b0000, 3'b000, 1, 3'd2, O_DEC, 16'd0);
        add(0, 4'b0000, 3'b000, 1, 3'd3, O_ALU, 16'd0);
        add(0, 4'b1010, 3'b000, 1, 3'd1, O_FR,  16'd1);  // LD with 2 wait cycles
        add(0, 4'b1010, 3'b000, 1, 3'd2, O_DEC, 16'd1);
        add(0, 4'b1010, 3'b000, 0, 3'd4, O_MLD, 16'd1);
        add(0, 4'b1010, 3'b000, 0, 3'd4, O_MLD, 16'd1);
        add(0, 4'b1010, 3'b000, 1, 3'd4, O_MLD, 16'd1);
        add(0, 4'b1010, 3'b000, 1, 3'd5, O_WB,  16'd1);
        add(0, 4'b1011, 3'b010, 1, 3'd1, O_FR,  16'd2);  // BRz taken
        add(0, 4'b1011, 3'b010, 1, 3'd2, O_DEC, 16'd2);
        add(0, 4'b1011, 3'b010, 1, 3'd3, O_BRT, 16'd2);
        add(0, 4'b1011, 3'b100, 1, 3'd1, O_FR,  16'd3);  // BRz not taken
        add(0, 4'b1011, 3'b100, 1, 3'd2, O_DEC, 16'd3);
        add(0, 4'b1011, 3'b100, 1, 3'd3, O_DEC, 16'd3);
        add(0, 4'b1100, 3'b100, 1, 3'd1, O_FR,  16'd4);  // BRn taken
        add(0, 4'b1100, 3'b100, 1, 3'd2, O_DEC, 16'd4);
        add(0, 4'b1100, 3'b100, 1, 3'd3, O_BRT, 16'd4);
        add(0, 4'b1101, 3'b001, 1, 3'd1, O_FR,  16'd5);  // BRp taken
        add(0, 4'b1101, 3'b001, 1, 3'd2, O_DEC, 16'd5);
        add(0, 4'b1101, 3'b001, 1, 3'd3, O_BRT, 16'd5);
        add(0, 4'b1110, 3'b000, 1, 3'd1, O_FR,  16'd6);  // JMP
        add(0, 4'b1110, 3'b000, 1, 3'd2, O_DEC, 16'd6);
        add(0, 4'b1110, 3'b000, 1, 3'd3, O_BRT, 16'd6);
        add(0, 4'b1001, 3'b000, 1, 3'd1, O_FR,  16'd7);  // ST
        add(0, 4'b1001, 3'b000, 1, 3'd2, O_DEC, 16'd7);
        add(0, 4'b1001, 3'b000, 1, 3'd4, O_MST, 16'd7);
        add(0, 4'b1111, 3'b000, 0, 3'd1, O_FW,  16'd8);  // HALT op, one fetch wait
        add(0, 4'b1111, 3'b000, 1, 3'd1, O_FR,  16'd8);
        add(0, 4'b1111, 3'b000, 1, 3'd2, O_DEC, 16'd8);
        add(0, 4'b1111, 3'b000, 1, 3'd6, O_HLT, 16'd9);
        add(0, 4'b1111, 3'b000, 1, 3'd6, O_HLT, 16'd9);
        add(1, 4'b1111, 3'b000, 1, 3'd6, O_HLT, 16'd9);
        add(0, 4'b0100, 3'b000, 0, 3'd1, O_FW,  16'd9);  // resume: no pc_we until ready
        add(0, 4'b0100, 3'b000, 1, 3'd1, O_FR,  16'd9);
        add(1, 4'b0100, 3'b000, 1, 3'd2, O_DEC, 16'd9);  // start while busy ignored
        add(1, 4'b0100, 3'b000, 1, 3'd3, O_ALU, 16'd9);
        add(0, 4'b0000, 3'b000, 1, 3'd1, O_FR,  16'd10);

        for (int i = 0; i < nv; i++) begin
            cyc(vecs[i].start, vecs[i].op, vecs[i].nzp, vecs[i].rdy);
            chk($sformatf("vec%0d", i), {state, outs, retired},
                {vecs[i].st, vecs[i].o, vecs[i].ret});
        end

        // Fetch timeout: ready never arrives.
        do_reset();
        cyc(1, 4'd0, 3'b000, 0);
        cyc(0, 4'd0, 3'b000, 0);
        n_fetch = 0;
        bad_we  = 1'b0;
        while (state == 3'd1 && n_fetch < 40) begin
            n_fetch++;
            if (ir_we || pc_we || reg_we || flags_we) bad_we = 1'b1;
            cyc(0, 4'd0, 3'b000, 0);
        end
        chk("timeout_wait_cycles", n_fetch, 15);
        chk("timeout_no_we", bad_we, 0);
        chk("timeout_halt", {state, halted, err, busy, retired}, {3'd6, 1'b1, 1'b1, 1'b0, 16'd0});
        cyc(1, 4'd0, 3'b000, 0);
        chk("timeout_err_sticky", {state, err}, {3'd6, 1'b1});
        cyc(0, 4'd0, 3'b000, 0);
        chk("timeout_resume", {state, err, pc_we}, {3'd1, 1'b0, 1'b0});
        cyc(0, 4'd0, 3'b000, 1);
        chk("timeout_resume_fetch", {state, ir_we, pc_we, pc_sel}, {3'd1, 1'b1, 1'b1, 1'b0});

        // Async reset in the middle of a store.
        do_reset();
        cyc(1, 4'd0, 3'b000, 1);
        cyc(0, 4'd0, 3'b000, 1);
        cyc(0, 4'd0, 3'b000, 1);
        cyc(0, 4'd0, 3'b000, 1);
        cyc(0, 4'b1001, 3'b000, 1);
        cyc(0, 4'b1001, 3'b000, 1);
        cyc(0, 4'b1001, 3'b000, 0);
        chk("st_mem_before_reset", {state, mem_req, mem_we, retired}, {3'd4, 1'b1, 1'b1, 16'd1});
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_store", {state, outs, retired}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_mem = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 4'b1001, 3'b000, 1);
            if (mem_we || mem_req || state != 3'd0) saw_mem = 1'b1;
        end
        chk("no_store_after_reset", saw_mem, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
